// File: rtl/warp_sequencer.sv
// Sequences one load/store/posit vector instruction across all warps of a block.
// Optional WAIT timeout watchdog enabled by defining WARP_SEQ_TIMEOUT_EN.
module warp_sequencer #(
  parameter int LANES      = 4,
  parameter int BLOCKDIM_W = 4,
  parameter int WARP_W     = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [BLOCKDIM_W-1:0] blockdim_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [WARP_W-1:0]     warp_o,
  output logic [LANES-1:0]      lane_mask_o,
  output logic                  rd_en_o,
  output logic                  unit_start_o,
  input  logic [LANES-1:0]      unit_done_i,
  output logic                  wb_en_o,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WAIT = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [1:0] OP_POSIT = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
  localparam int CW = BLOCKDIM_W + WARP_W + $clog2(LANES) + 1;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("TIMEOUT must fit the 8-bit WAIT counter");
  end
  if (((1 << BLOCKDIM_W) - 1 + LANES - 1) / LANES > (1 << WARP_W)) begin : g_warp_range
    $error("WARP_W too narrow for BLOCKDIM_W/LANES");
  end

  // Lane l of warp w is active when blockdim > w*LANES + l.
  function automatic logic [LANES-1:0] lane_mask_f(input logic [BLOCKDIM_W-1:0] bd,
                                                    input logic [WARP_W-1:0] w);
    logic [CW-1:0]    base;
    logic [LANES-1:0] m;
    base = CW'(w) * CW'(LANES);
    for (int l = 0; l < LANES; l++) begin
      m[l] = (CW'(bd) > (base + CW'(l)));
    end
    return m;
  endfunction

  function automatic logic [WARP_W-1:0] last_warp_f(input logic [BLOCKDIM_W-1:0] bd);
    logic [CW-1:0] n;
    n = (CW'(bd) + CW'(LANES - 1)) / CW'(LANES);
    return WARP_W'(n - CW'(1));
  endfunction

  state_e                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [BLOCKDIM_W-1:0]   bd_q, bd_d;
  logic [WARP_W-1:0]       last_q, last_d;
  logic [WARP_W-1:0]       warp_q, warp_d;
  logic                    err_q, err_d;
  logic                    all_done_s;

  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    rd_q, rd_d;
  logic                    ustart_q, ustart_d;
  logic                    wb_q, wb_d;
  logic [WARP_W-1:0]       warpo_q, warpo_d;
  logic [LANES-1:0]        mask_q, mask_d;
  logic                    active_s;

`ifdef WARP_SEQ_TIMEOUT_EN
  logic [7:0]              cnt_q, cnt_d;
`endif

  // Unmasked lanes count as done so partial warps never stall.
  assign all_done_s = &(unit_done_i | ~mask_q);

  // Next-state and control-register logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    bd_d    = bd_q;
    last_d  = last_q;
    warp_d  = warp_q;
    err_d   = err_q;
`ifdef WARP_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          warp_d = {WARP_W{1'b0}};
          if (op_i == OP_RSVD) begin
            err_d   = 1'b1;
            op_d    = 2'b00;
            bd_d    = {BLOCKDIM_W{1'b0}};
            last_d  = {WARP_W{1'b0}};
            state_d = S_DONE;
          end else begin
            err_d  = 1'b0;
            op_d   = op_i;
            bd_d   = blockdim_i;
            last_d = last_warp_f(blockdim_i);
            if (blockdim_i == {BLOCKDIM_W{1'b0}}) begin
              state_d = S_DONE;
            end else begin
              state_d = S_READ;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (op_q == OP_POSIT) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_WB;
        end
      end
      S_EXEC: begin
        state_d = S_WAIT;
`ifdef WARP_SEQ_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      S_WAIT: begin
        if (all_done_s) begin
          state_d = S_WB;
`ifdef WARP_SEQ_TIMEOUT_EN
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`else
        end else begin
          state_d = S_WAIT;
`endif
        end
      end
      S_WB: begin
        if (warp_q == last_q) begin
          state_d = S_DONE;
        end else begin
          warp_d  = warp_q + WARP_W'(1);
          state_d = S_READ;
        end
      end
      S_DONE: begin
        warp_d  = {WARP_W{1'b0}};
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the next state so the registers line up with state_q.
  always_comb begin
    active_s = (state_d == S_READ) || (state_d == S_EXEC) ||
               (state_d == S_WAIT) || (state_d == S_WB);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    rd_d     = (state_d == S_READ);
    ustart_d = (state_d == S_EXEC) || (state_d == S_WAIT);
    wb_d     = (state_d == S_WB);
    if (active_s) begin
      warpo_d = warp_d;
      mask_d  = lane_mask_f(bd_d, warp_d);
    end else begin
      warpo_d = {WARP_W{1'b0}};
      mask_d  = {LANES{1'b0}};
    end
  end

  // State, captured instruction and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      bd_q     <= {BLOCKDIM_W{1'b0}};
      last_q   <= {WARP_W{1'b0}};
      warp_q   <= {WARP_W{1'b0}};
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_q     <= 1'b0;
      ustart_q <= 1'b0;
      wb_q     <= 1'b0;
      warpo_q  <= {WARP_W{1'b0}};
      mask_q   <= {LANES{1'b0}};
`ifdef WARP_SEQ_TIMEOUT_EN
      cnt_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      bd_q     <= bd_d;
      last_q   <= last_d;
      warp_q   <= warp_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_q     <= rd_d;
      ustart_q <= ustart_d;
      wb_q     <= wb_d;
      warpo_q  <= warpo_d;
      mask_q   <= mask_d;
`ifdef WARP_SEQ_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign warp_o       = warpo_q;
  assign lane_mask_o  = mask_q;
  assign rd_en_o      = rd_q;
  assign unit_start_o = ustart_q;
  assign wb_en_o      = wb_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_warp_sequencer.sv
// Table-driven bench for warp_sequencer plus hand-written reset/timeout sequences.
module tb_warp_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [1:0] op_i;
  logic [3:0] blockdim_i;
  logic       busy_o, done_o;
  logic [1:0] warp_o;
  logic [3:0] lane_mask_o;
  logic       rd_en_o, unit_start_o, wb_en_o, err_o;
  logic [3:0] unit_done_i;

  int checks   = 0;
  int failures = 0;

  warp_sequencer #(.LANES(4), .BLOCKDIM_W(4), .WARP_W(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .blockdim_i(blockdim_i),
    .busy_o(busy_o), .done_o(done_o), .warp_o(warp_o), .lane_mask_o(lane_mask_o),
    .rd_en_o(rd_en_o), .unit_start_o(unit_start_o), .unit_done_i(unit_done_i),
    .wb_en_o(wb_en_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  bd;
    logic [3:0]  done_pat;
    int          wdelay;
    int          mid;
    int          lat;
    int          rd;
    int          wb;
    int          us;
    logic        err;
    logic [15:0] rmasks;
    logic [15:0] masks;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] bd, input logic [3:0] pat,
                              input int wdelay, input int mid, input int lat, input int rd,
                              input int wb, input int us, input logic err,
                              input logic [15:0] rmasks, input logic [15:0] masks);
    vec_t v;
    v.op = op; v.bd = bd; v.done_pat = pat; v.wdelay = wdelay; v.mid = mid;
    v.lat = lat; v.rd = rd; v.wb = wb; v.us = us; v.err = err;
    v.rmasks = rmasks; v.masks = masks;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issues one instruction, emulates the posit units, and checks the whole trace.
  task automatic run_vec(input vec_t v, input int id);
    int          cyc, n_rd, n_wb, n_us, n_busy, ucnt, lat_at;
    logic [15:0] m_rd, m_wb;
    logic        seen, err_at, zero_at;
    n_rd = 0; n_wb = 0; n_us = 0; n_busy = 0; ucnt = 0; lat_at = 0;
    m_rd = 16'h0000; m_wb = 16'h0000; seen = 1'b0; err_at = 1'b0; zero_at = 1'b0;
    op_i = v.op; blockdim_i = v.bd; start_i = 1'b1; unit_done_i = 4'b0000;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 2'b00; blockdim_i = 4'h0;
    cyc = 1;
    while (!seen && cyc <= 300) begin
      if (rd_en_o) begin n_rd++; m_rd[int'(warp_o)*4 +: 4] = lane_mask_o; end
      if (wb_en_o) begin n_wb++; m_wb[int'(warp_o)*4 +: 4] = lane_mask_o; end
      if (busy_o) n_busy++;
      if (unit_start_o) begin n_us++; ucnt++; end else ucnt = 0;
      unit_done_i = (ucnt == v.wdelay + 1) ? v.done_pat : 4'b0000;
      if (cyc == v.mid) begin
        start_i = 1'b1; op_i = 2'b10; blockdim_i = 4'hF;
      end else begin
        start_i = 1'b0; op_i = 2'b00; blockdim_i = 4'h0;
      end
      if (done_o) begin
        seen    = 1'b1;
        lat_at  = cyc;
        err_at  = err_o;
        zero_at = (warp_o == 2'd0) && (lane_mask_o == 4'd0) && !rd_en_o && !wb_en_o && !unit_start_o && busy_o;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check($sformatf("v%0d_done_seen", id), 32'(seen), 32'd1);
    check($sformatf("v%0d_latency", id), 32'(lat_at), 32'(v.lat));
    check($sformatf("v%0d_rd_pulses", id), 32'(n_rd), 32'(v.rd));
    check($sformatf("v%0d_wb_pulses", id), 32'(n_wb), 32'(v.wb));
    check($sformatf("v%0d_ustart_cycles", id), 32'(n_us), 32'(v.us));
    check($sformatf("v%0d_busy_cycles", id), 32'(n_busy), 32'(v.lat));
    check($sformatf("v%0d_err_at_done", id), 32'(err_at), 32'(v.err));
    check($sformatf("v%0d_rd_masks", id), 32'(m_rd), 32'(v.rmasks));
    check($sformatf("v%0d_wb_masks", id), 32'(m_wb), 32'(v.masks));
    check($sformatf("v%0d_done_outputs", id), 32'(zero_at), 32'd1);
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 2'b00; blockdim_i = 4'h0; unit_done_i = 4'b0000;
    check($sformatf("v%0d_post_idle", id), {29'd0, busy_o, done_o, err_o}, {29'd0, 1'b0, 1'b0, v.err});
  endtask

  initial begin
    int k;
    rst = 1'b1; start_i = 1'b0; op_i = 2'b00; blockdim_i = 4'h0; unit_done_i = 4'b0000;

    //                op     bd    pat    wd mid lat rd wb us err rmask     wmask
    vecs[0] = mk(2'b00, 4'd6,  4'h0, 0, 0, 5, 2, 2, 0, 1'b0, 16'h003F, 16'h003F);
    vecs[1] = mk(2'b00, 4'd6,  4'h0, 0, 2, 5, 2, 2, 0, 1'b0, 16'h003F, 16'h003F);
    vecs[2] = mk(2'b01, 4'd15, 4'h0, 0, 9, 9, 4, 4, 0, 1'b0, 16'h7FFF, 16'h7FFF);
    vecs[3] = mk(2'b10, 4'd4,  4'hF, 2, 0, 6, 1, 1, 3, 1'b0, 16'h000F, 16'h000F);
    vecs[4] = mk(2'b10, 4'd3,  4'h7, 1, 0, 5, 1, 1, 2, 1'b0, 16'h0007, 16'h0007);
    vecs[5] = mk(2'b00, 4'd0,  4'h0, 0, 0, 1, 0, 0, 0, 1'b0, 16'h0000, 16'h0000);
    vecs[6] = mk(2'b11, 4'd5,  4'h0, 0, 0, 1, 0, 0, 0, 1'b1, 16'h0000, 16'h0000);
    vecs[7] = mk(2'b01, 4'd1,  4'h0, 0, 0, 3, 1, 1, 0, 1'b0, 16'h0001, 16'h0001);
    vecs[8] = mk(2'b10, 4'd5,  4'hF, 1, 0, 9, 2, 2, 4, 1'b0, 16'h001F, 16'h001F);
    vecs[9] = mk(2'b00, 4'd4,  4'h0, 0, 0, 3, 1, 1, 0, 1'b0, 16'h000F, 16'h000F);

    @(posedge clk); #1;
    check("reset_outputs",
          {20'd0, busy_o, done_o, warp_o, lane_mask_o, rd_en_o, unit_start_o, wb_en_o, err_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end

`ifdef WARP_SEQ_TIMEOUT_EN
    run_vec(mk(2'b10, 4'd4, 4'h0, 1000, 0, 11, 1, 0, 9, 1'b1, 16'h000F, 16'h0000), 10);
    run_vec(vecs[9], 11);
`endif

    // Asynchronous reset while parked in WAIT with no unit done.
    op_i = 2'b10; blockdim_i = 4'd4; start_i = 1'b1; unit_done_i = 4'b0000;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 2'b00; blockdim_i = 4'h0;
    for (k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    check("wait_before_reset", {30'd0, busy_o, unit_start_o}, 32'd3);
    #2 rst = 1'b1;
    #1;
    check("reset_in_wait",
          {20'd0, busy_o, done_o, warp_o, lane_mask_o, rd_en_o, unit_start_o, wb_en_o, err_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", {30'd0, busy_o, done_o}, 32'd0);
    run_vec(vecs[0], 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/warp_sequencer.md
Name: warp_sequencer

Overview:
- Control FSM that sequences one vector instruction (load, store or posit op) across all warps of a block in the posit vector processor.
- Computes warp count and per-warp lane masks from blockdim.
- Issues read, execute and write-back strobes to the register files, global memory and posit units, and handshakes with the units' start/done signals.
- Removes the ad-hoc warp/pipeline counters from the top level. The top level only decodes instructions and forwards start_i.

Parameters:
- LANES, 4, number of lanes (register files / posit units) per warp.
- BLOCKDIM_W, 4, width of the blockdim field.
- WARP_W, 2, width of the warp index. Must satisfy ceil((2^BLOCKDIM_W - 1)/LANES) <= 2^WARP_W.
- TIMEOUT, 255, maximum WAIT cycles. Used only when the optional feature is enabled.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle instruction start. Honoured only in IDLE.
- op_i  in  2  00 load, 01 store, 10 posit op, 11 reserved. Sampled with start_i.
- blockdim_i  in  BLOCKDIM_W  number of active threads. Sampled with start_i.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- warp_o  out  WARP_W  index of the warp currently sequenced.
- lane_mask_o  out  LANES  active lanes of the current warp.
- rd_en_o  out  1  read phase strobe: RF operand read, or GB read for load.
- unit_start_o  out  1  start to the posit units.
- unit_done_i  in  LANES  per-lane posit unit done.
- wb_en_o  out  1  write-back strobe. Top level ANDs it per lane with lane_mask_o: RF write for load/op, GB write for store.
- err_o  out  1  sticky error flag. Cleared on the next accepted start.

Behaviour:
- Reset (async, any state including mid-operation):
  - state goes to IDLE.
  - All outputs go to 0; warp counter, captured op and captured blockdim are cleared.
- Outputs are registered, Moore-style: valid during the cycle the FSM is in the named state.
- Setup at start: nwarps = ceil(blockdim/LANES), computed once at start and held.
- Lane mask for warp w:
  - rem = blockdim - w*LANES.
  - Lanes 0..min(rem,LANES)-1 are set.
  - Example, blockdim=6, LANES=4: w0 = 1111, w1 = 0011.
- States:
  - IDLE: start_i=1 with op_i 00/01/10 captures op and blockdim, sets warp to 0, clears err_o.
    - Goes to DONE if blockdim=0; no strobes are issued.
    - Otherwise goes to READ.
    - op_i=11 goes to DONE with err_o=1.
  - READ: rd_en_o=1 for one cycle. Goes to WB for load/store, EXEC for posit op.
  - EXEC: unit_start_o=1. Goes to WAIT.
  - WAIT: unit_start_o stays 1. Goes to WB in the cycle after all masked lanes have unit_done_i=1. Unmasked lanes' done bits are ignored.
  - WB: wb_en_o=1 for one cycle, unit_start_o=0. If warp = nwarps-1, goes to DONE. Otherwise warp increments and goes to READ.
  - DONE: done_o=1, busy_o=1. Goes to IDLE.
- Latency from the start edge to the done_o pulse:
  - load/store: 2*nwarps + 1 cycles.
  - posit op: nwarps*(3 + wait cycles) + 1 cycles.
- start_i outside IDLE, including the DONE cycle, is ignored with no side effects.
- warp_o and lane_mask_o are stable from READ through WB of each warp. In IDLE and DONE they hold 0.

Optional Feature:
- Macro WARP_SEQ_TIMEOUT_EN.
- When defined:
  - An 8-bit counter runs in WAIT and is cleared on entry.
  - If it reaches TIMEOUT without all masked dones, the FSM sets err_o=1 and goes directly to DONE.
  - No wb_en_o is issued for that warp or any later warp.
- When undefined:
  - WAIT lasts until done, with no limit.
  - err_o is set only by the reserved opcode.
  - No counter logic is present.

Test Plan:
- Load, blockdim=6:
  - rd_en_o/wb_en_o alternate for 4 cycles: warp 0 with mask 1111, then warp 1 with mask 0011.
  - done_o pulses 5 cycles after the start edge; busy_o falls the cycle after.
- Posit op, blockdim=4, unit_done_i=1111 two cycles after EXEC: sequence is READ, EXEC, WAIT x2, WB, DONE; exactly one wb_en_o pulse.
- Posit op, blockdim=3, unit_done_i=0111 (lane 3 never done): completes normally, because lane 3 is unmasked.
- Edge cases on opcode and blockdim:
  - blockdim=0 gives done_o one cycle after start with no strobes.
  - op_i=11 gives done_o with err_o=1.
  - A following valid start clears err_o.
- Busy and reset interactions:
  - start_i pulsed mid-load is ignored, with no change in warp count or mask.
  - rst asserted in WAIT drops all outputs to 0 immediately, then IDLE.
- WARP_SEQ_TIMEOUT_EN with TIMEOUT=8 and dones held at 0: err_o=1 and done_o after 8 WAIT cycles, with no wb_en_o.
